alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Shares one 7-bit ALU instance (NOT / ROR with CF, SF, ZF flags) between two requesters.
- Each requester uses a valid/ready command handshake. The arbiter grants one requester at a time, registers the operands, runs the ALU, and registers the result and flags.
- The registered result is returned on a single response channel with backpressure.
- Sits between the two instruction-issue sources and the ALU datapath; the ALU is instantiated inside this block.

## Interface
- FAIR, default 1: 1 = round-robin between requesters; 0 = fixed priority, req0 always wins.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_a, req0_b  in  7 each  requester 0 operands.
- req0_op  in  2  requester 0 opcode: 00 NOT, 01 ROR, 10/11 illegal.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the command.
- rsp_r  out  7  ALU result.
- rsp_cf, rsp_sf, rsp_zf  out  1 each  ALU flags.
- busy  out  1  high in any state other than IDLE.
- ops_done  out  8  count of completed responses; saturates at 255.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally. The only valid requester wins. If both are valid, the priority requester wins.
  - The granted reqN_ready is driven high in the same cycle. The handshake is reqN_valid & reqN_ready.
  - On handshake, latch a/b/op and the grant id into internal registers, then go to EXEC.
  - The ungranted requester's ready stays low.
- EXEC: the ALU sees only the latched operands. On the clock edge, capture R, CF, SF, ZF and go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* stay stable until rsp_valid & rsp_ready.
  - On that handshake: go to IDLE, increment ops_done (hold at 255), clear rsp_valid.
- Round-robin (FAIR=1):
  - 1-bit pointer, reset value = requester 0 has priority.
  - On each accepted command, priority passes to the requester that was not granted.
  - The pointer changes only on accept, never while both requesters are idle.
- ALU semantics, from the latched operands:
  - NOT: R = ~A, CF = 0.
  - ROR: R = A rotated right by B[2:0]; CF = A[B mod 7], with B as unsigned 7 bits.
  - Illegal opcodes: R = 0, CF = 0.
  - For all ops: SF = R[6], ZF = (R == 0).
- Requesters must hold valid and operands stable until ready. Dropping valid before ready withdraws the command and is legal.

## Timing
- Reset values:
  - State IDLE; rsp_valid 0; rsp_r 0; rsp_cf, rsp_sf, rsp_zf 0; rsp_id 0.
  - ops_done 0; busy 0; priority pointer = requester 0.
  - req0_ready and req1_ready are 0 during the reset cycle.
- Latency:
  - Accept edge at cycle N → rsp_valid high in cycle N+2 at the earliest.
  - With rsp_ready held at 1, the next accept is possible in cycle N+3. Peak throughput is one op per 3 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely. No request is accepted while busy.
- Simultaneous events: rsp handshake and new reqN_valid in the same cycle → the new request is accepted in the following cycle (IDLE), not the same cycle.
- Reset mid-operation (EXEC or RESP):
  - The in-flight command is dropped with no response.
  - ops_done is not incremented, and then reset to 0.
- ops_done at 255: a further completion leaves it at 255; no wrap to 0.
- Ready depends on valid combinationally. Valid must not depend on ready.

## Test plan
- Reset, then req0 NOT with A=7'h00, rsp_ready=1 → req0_ready in cycle 0. rsp_valid in cycle 2 with rsp_r=7'h7F, sf=1, zf=0, cf=0, rsp_id=0. ops_done=1.
- req1 ROR with A=7'b0000001, B=7'd1 → rsp_r=7'b1000000, cf=A[1]=0, sf=1, zf=0, rsp_id=1.
- Both requesters valid continuously, FAIR=1 → grant order 0,1,0,1. With FAIR=0 → all grants to 0; req1_ready never high.
- op=2'b10 with A=7'h55 → rsp_r=0, zf=1, sf=0, cf=0.
- rsp_ready low for 5 cycles in RESP → rsp_* stable, busy=1, both readys low. The response completes on the cycle rsp_ready rises.
- rst asserted in EXEC → next cycle IDLE, rsp_valid=0, ops_done=0, no response. 256 completions → ops_done stays at 255.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter around a 7-bit NOT/ROR ALU: accept -> EXEC -> RESP, response valid two cycles after accept.
// One command in flight; requests are refused while busy and rsp_ready low holds the response indefinitely.
module alu_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [6:0] req0_a,
  input  logic [6:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [6:0] req1_a,
  input  logic [6:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [6:0] rsp_r,
  output logic       rsp_cf,
  output logic       rsp_sf,
  output logic       rsp_zf,
  output logic       busy,
  output logic [7:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic       prio;
  logic       gnt;
  logic       accept;
  logic [6:0] a_q;
  logic [6:0] b_q;
  logic [1:0] op_q;
  logic       id_q;
  logic [6:0] rot;
  logic [2:0] bmod;
  logic [6:0] alu_r;
  logic       alu_cf;

  // gnt selects requester 1; on a tie the priority pointer (or req0 when not fair) wins
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) gnt = FAIR ? prio : 1'b0;
    else                          gnt = req1_valid;
  end

  assign accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;
  assign busy       = (state != IDLE);

  // A rotation by 7 on a 7-bit word is the identity, which the doubled word gives for free
  assign rot  = 7'({a_q, a_q} >> b_q[2:0]);
  assign bmod = 3'(b_q % 7'd7);

  always_comb begin
    alu_r  = 7'd0;
    alu_cf = 1'b0;
    case (op_q)
      2'b00: alu_r = ~a_q;
      2'b01: begin
        alu_r  = rot;
        alu_cf = a_q[bmod];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      a_q       <= 7'd0;
      b_q       <= 7'd0;
      op_q      <= 2'b00;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= 7'd0;
      rsp_cf    <= 1'b0;
      rsp_sf    <= 1'b0;
      rsp_zf    <= 1'b0;
      ops_done  <= 8'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q   <= gnt ? req1_a  : req0_a;
          b_q   <= gnt ? req1_b  : req0_b;
          op_q  <= gnt ? req1_op : req0_op;
          id_q  <= gnt;
          prio  <= FAIR ? ~gnt : 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          rsp_r     <= alu_r;
          rsp_cf    <= alu_cf;
          rsp_sf    <= alu_r[6];
          rsp_zf    <= (alu_r == 7'd0);
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          if (ops_done != 8'hFF) ops_done <= ops_done + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter (fair and fixed-priority instances share stimulus).
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [6:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;

  logic       f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_cf, f_rsp_sf, f_rsp_zf, f_busy;
  logic [6:0] f_rsp_r;
  logic [7:0] f_ops_done;
  logic       x_req0_ready, x_req1_ready, x_rsp_valid, x_rsp_id, x_rsp_cf, x_rsp_sf, x_rsp_zf, x_busy;
  logic [6:0] x_rsp_r;
  logic [7:0] x_ops_done;

  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] m_ops;
  bit   m_prio;

  always #5 clk = ~clk;

  alu_arbiter #(.FAIR(1'b1)) u_fair (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id), .rsp_r(f_rsp_r),
    .rsp_cf(f_rsp_cf), .rsp_sf(f_rsp_sf), .rsp_zf(f_rsp_zf), .busy(f_busy), .ops_done(f_ops_done)
  );

  alu_arbiter #(.FAIR(1'b0)) u_fix (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(x_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(x_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(x_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(x_rsp_id), .rsp_r(x_rsp_r),
    .rsp_cf(x_rsp_cf), .rsp_sf(x_rsp_sf), .rsp_zf(x_rsp_zf), .busy(x_busy), .ops_done(x_ops_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the operation rules: {cf, sf, zf, r}
  function automatic logic [9:0] ref_alu(input logic [6:0] a, input logic [6:0] b, input logic [1:0] op);
    logic [6:0] r;
    logic       cf;
    int         s;
    r  = 7'd0;
    cf = 1'b0;
    if (op == 2'd0) r = ~a;
    else if (op == 2'd1) begin
      s = int'(b) % 8;
      for (int i = 0; i < 7; i++) r[i] = a[(i + s) % 7];
      cf = a[int'(b) % 7];
    end
    return {cf, r[6], (r == 7'd0), r};
  endfunction

  task automatic chk_rsp(input logic [9:0] e, input bit g);
    chk("rsp_valid", {7'd0, f_rsp_valid}, 8'd1);
    chk("rsp_r",  {1'b0, f_rsp_r}, {1'b0, e[6:0]});
    chk("rsp_zf", {7'd0, f_rsp_zf}, {7'd0, e[7]});
    chk("rsp_sf", {7'd0, f_rsp_sf}, {7'd0, e[8]});
    chk("rsp_cf", {7'd0, f_rsp_cf}, {7'd0, e[9]});
    chk("rsp_id", {7'd0, f_rsp_id}, {7'd0, g});
  endtask

  // Called in IDLE just after a falling edge with requests already driven.
  task automatic run_op(input int stall, input bit chk_fixed, output bit g);
    logic [9:0] e;
    #1;
    g = (req0_valid && req1_valid) ? m_prio : req1_valid;
    chk("idle_busy", {7'd0, f_busy}, 8'd0);
    chk("req0_ready", {7'd0, f_req0_ready}, {7'd0, !g});
    chk("req1_ready", {7'd0, f_req1_ready}, {7'd0, g});
    if (chk_fixed) begin
      chk("fix_req0_ready", {7'd0, x_req0_ready}, 8'd1);
      chk("fix_req1_ready", {7'd0, x_req1_ready}, 8'd0);
    end
    e = g ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
    m_prio = !g;
    @(negedge clk);
    #1;
    chk("exec_rsp_valid", {7'd0, f_rsp_valid}, 8'd0);
    chk("exec_busy", {7'd0, f_busy}, 8'd1);
    chk("exec_readys", {6'd0, f_req1_ready, f_req0_ready}, 8'd0);
    rsp_ready = (stall == 0);
    @(negedge clk);
    for (int s = 0; s < stall; s++) begin
      #1;
      chk_rsp(e, g);
      chk("stall_busy", {7'd0, f_busy}, 8'd1);
      chk("stall_readys", {6'd0, f_req1_ready, f_req0_ready}, 8'd0);
      @(negedge clk);
      if (s == stall - 1) rsp_ready = 1'b1;
    end
    #1;
    chk_rsp(e, g);
    if (chk_fixed) begin
      chk("fix_rsp_valid", {7'd0, x_rsp_valid}, 8'd1);
      chk("fix_rsp_id", {7'd0, x_rsp_id}, 8'd0);
    end
    @(negedge clk);
    if (m_ops != 8'd255) m_ops++;
    #1;
    chk("done_rsp_valid", {7'd0, f_rsp_valid}, 8'd0);
    chk("done_busy", {7'd0, f_busy}, 8'd0);
    chk("ops_done", f_ops_done, m_ops);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ops = 8'd0;
    m_prio = 1'b0;
  endtask

  initial begin
    bit g, p0, p1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = 7'd0; req0_b = 7'd0; req0_op = 2'd0;
    req1_a = 7'd0; req1_b = 7'd0; req1_op = 2'd0;
    m_ops = 8'd0; m_prio = 1'b0;

    // Reset state, with a request pending during the reset cycle
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", {7'd0, f_req0_ready}, 8'd0);
    chk("rst_fix_req0_ready", {7'd0, x_req0_ready}, 8'd0);
    chk("rst_rsp_valid", {7'd0, f_rsp_valid}, 8'd0);
    chk("rst_rsp_r", {1'b0, f_rsp_r}, 8'd0);
    chk("rst_flags", {4'd0, f_rsp_cf, f_rsp_sf, f_rsp_zf, f_rsp_id}, 8'd0);
    chk("rst_ops_done", f_ops_done, 8'd0);
    chk("rst_busy", {7'd0, f_busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // req0 NOT of zero
    run_op(0, 0, g);
    req0_valid = 1'b0;

    // req1 ROR by 1
    req1_valid = 1'b1; req1_a = 7'b0000001; req1_b = 7'd1; req1_op = 2'b01;
    run_op(0, 0, g);
    req1_valid = 1'b0;

    // Illegal opcode
    req0_valid = 1'b1; req0_a = 7'h55; req0_b = 7'h12; req0_op = 2'b10;
    run_op(0, 0, g);

    // Five cycles of response backpressure with both requesters waiting
    req0_a = 7'h2B; req0_b = 7'h0D; req0_op = 2'b01;
    req1_valid = 1'b1; req1_a = 7'h40; req1_b = 7'h7F; req1_op = 2'b01;
    run_op(5, 0, g);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Both requesters continuously valid: fair alternates, fixed always picks req0
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_op(0, 1, g);
      if (g) begin
        req1_a = 7'($urandom); req1_b = 7'($urandom); req1_op = 2'($urandom);
      end else begin
        req0_a = 7'($urandom); req0_b = 7'($urandom); req0_op = 2'($urandom);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset while in EXEC drops the command
    req0_valid = 1'b1; req0_a = 7'h11; req0_b = 7'h03; req0_op = 2'b01;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstx_readys", {6'd0, f_req1_ready, f_req0_ready}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    m_ops = 8'd0; m_prio = 1'b0;
    #1;
    chk("rstx_rsp_valid", {7'd0, f_rsp_valid}, 8'd0);
    chk("rstx_busy", {7'd0, f_busy}, 8'd0);
    chk("rstx_ops_done", f_ops_done, 8'd0);
    @(negedge clk);
    #1;
    chk("rstx_no_rsp", {7'd0, f_rsp_valid}, 8'd0);

    // Randomized traffic; a requester that loses keeps its command presented
    p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin
        p0 = 1'b1; req0_a = 7'($urandom); req0_b = 7'($urandom); req0_op = 2'($urandom);
      end
      if (!p1 && $urandom_range(1, 0) == 1) begin
        p1 = 1'b1; req1_a = 7'($urandom); req1_b = 7'($urandom); req1_op = 2'($urandom);
      end
      if (!p0 && !p1) begin
        p0 = 1'b1; req0_a = 7'($urandom); req0_b = 7'($urandom); req0_op = 2'($urandom);
      end
      req0_valid = p0; req1_valid = p1;
      run_op(int'($urandom_range(3, 0)), 0, g);
      if (g) p1 = 1'b0; else p0 = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Saturation of the completion counter
    do_reset();
    req0_valid = 1'b1;
    for (int n = 0; n < 257; n++) begin
      req0_a = 7'($urandom); req0_b = 7'($urandom); req0_op = 2'($urandom);
      run_op(0, 0, g);
    end
    req0_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
